// File: rtl/rx_host_ctrl.sv
// UART receive-side host controller: capture FSM feeding a show-ahead FIFO with sticky error flags.
// Optional build macro RX_HOST_ERR_DROP_EN: words captured with a framing error are discarded instead of queued.
module rx_host_ctrl #(
    parameter int wordSize  = 8,
    parameter int fifoDepth = 4
) (
    input  logic                         sampleClk,
    input  logic                         rst_b,
    input  logic [wordSize-1:0]          rxDatareg,
    input  logic                         received,
    input  logic                         error,
    input  logic                         halt,
    output logic                         notReady,
    output logic [wordSize-1:0]          hostData,
    output logic                         hostValid,
    input  logic                         hostReady,
    output logic [$clog2(fifoDepth):0]   fifoCount,
    output logic                         overrun,
    output logic                         frameErr,
    input  logic                         errClr
);

    localparam int ptrWidth = $clog2(fifoDepth);
    localparam int cntWidth = ptrWidth + 1;
    localparam logic [cntWidth-1:0] fullCount = cntWidth'(fifoDepth);

    typedef enum logic [1:0] {IDLE, STORE, HOLD} stateT;

    stateT                stateReg, stateNext;
    logic                 captureEn;
    logic                 armedReg;
    logic [wordSize-1:0]  wordReg;
    logic                 errReg;
    logic [wordSize-1:0]  memReg [fifoDepth];
    logic [ptrWidth-1:0]  wrPtrReg, rdPtrReg;
    logic [cntWidth-1:0]  countReg;
    logic                 overrunReg, frameErrReg;

    logic inStore, pop, push, pushPermitted, dropWord;
    logic overrunSet, frameErrSet;

    always_comb begin
        stateNext = stateReg;
        captureEn = 1'b0;
        case (stateReg)
            IDLE: begin
                // armedReg blocks a level left high across reset from counting as a new word
                if (received && armedReg) begin
                    stateNext = STORE;
                    captureEn = 1'b1;
                end
            end
            STORE: stateNext = HOLD;
            HOLD: begin
                if (!received) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef RX_HOST_ERR_DROP_EN
    assign dropWord = errReg;
`else
    assign dropWord = 1'b0;
`endif

    assign inStore       = (stateReg == STORE);
    assign pop           = (countReg != '0) && hostReady;
    assign pushPermitted = (countReg != fullCount) || pop;
    assign push          = inStore && pushPermitted && !dropWord;
    assign overrunSet    = (inStore && !pushPermitted && !dropWord) || (halt && !notReady);
    assign frameErrSet   = inStore && errReg && (pushPermitted || dropWord);

    always_ff @(posedge sampleClk) begin
        if (!rst_b) begin
            stateReg    <= IDLE;
            armedReg    <= 1'b0;
            wordReg     <= '0;
            errReg      <= 1'b0;
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            overrunReg  <= 1'b0;
            frameErrReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (!received) begin
                armedReg <= 1'b1;
            end
            if (captureEn) begin
                wordReg <= rxDatareg;
                errReg  <= error;
            end
            if (push) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            case ({push, pop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
            // a set event in the same cycle as errClr wins
            if (overrunSet) begin
                overrunReg <= 1'b1;
            end else if (errClr) begin
                overrunReg <= 1'b0;
            end
            if (frameErrSet) begin
                frameErrReg <= 1'b1;
            end else if (errClr) begin
                frameErrReg <= 1'b0;
            end
        end
    end

    // Storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge sampleClk) begin
        if (rst_b && push) begin
            memReg[wrPtrReg] <= wordReg;
        end
    end

    assign hostValid = (countReg != '0);
    assign hostData  = hostValid ? memReg[rdPtrReg] : '0;
    assign notReady  = (countReg == fullCount);
    assign fifoCount = countReg;
    assign overrun   = overrunReg;
    assign frameErr  = frameErrReg;

endmodule

// File: tb/tb_rx_host_ctrl.sv
// Directed self-checking bench for rx_host_ctrl: capture latency, full/overrun, errors, reset, wrap.
module tb_rx_host_ctrl;

    logic       sampleClk;
    logic       rst_b;
    logic [7:0] rxDatareg;
    logic       received;
    logic       error;
    logic       halt;
    logic       notReady;
    logic [7:0] hostData;
    logic       hostValid;
    logic       hostReady;
    logic [2:0] fifoCount;
    logic       overrun;
    logic       frameErr;
    logic       errClr;

    int testCount = 0;
    int failCount = 0;
    int maxCount  = 0;

    rx_host_ctrl #(.wordSize(8), .fifoDepth(4)) dut (
        .sampleClk (sampleClk),
        .rst_b     (rst_b),
        .rxDatareg (rxDatareg),
        .received  (received),
        .error     (error),
        .halt      (halt),
        .notReady  (notReady),
        .hostData  (hostData),
        .hostValid (hostValid),
        .hostReady (hostReady),
        .fifoCount (fifoCount),
        .overrun   (overrun),
        .frameErr  (frameErr),
        .errClr    (errClr)
    );

    initial begin
        sampleClk = 1'b0;
        forever #5 sampleClk = ~sampleClk;
    end

    task automatic tick();
        @(posedge sampleClk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One received pulse: rise, STORE edge, then drop and return to IDLE.
    task automatic sendWord(input logic [7:0] data, input logic err);
        rxDatareg = data;
        error     = err;
        received  = 1'b1;
        tick();
        tick();
        received  = 1'b0;
        error     = 1'b0;
        tick();
        $display("[TB] sent word 0x%02h err=%0d count=%0d", data, err, fifoCount);
    endtask

    task automatic popWord(input logic [7:0] exp, input string tag);
        checkVal(tag, hostData, exp);
        hostReady = 1'b1;
        tick();
        hostReady = 1'b0;
        $display("[TB] popped word expected 0x%02h", exp);
    endtask

    task automatic clearFlags();
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; rxDatareg = '0; received = 1'b0; error = 1'b0;
        halt = 1'b0; hostReady = 1'b0; errClr = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        checkVal("rst_count", fifoCount, 0);
        checkVal("rst_valid", hostValid, 0);
        checkVal("rst_data", hostData, 0);
        checkVal("rst_notready", notReady, 0);
        checkVal("rst_flags", {overrun, frameErr}, 0);

        // Latency: visible two edges after received rises
        rxDatareg = 8'hA5;
        received  = 1'b1;
        tick();
        checkVal("lat_valid_early", hostValid, 0);
        tick();
        checkVal("lat_valid", hostValid, 1);
        checkVal("lat_data", hostData, 8'hA5);
        checkVal("lat_count", fifoCount, 1);
        received = 1'b0;
        tick();
        popWord(8'hA5, "lat_pop");
        checkVal("lat_empty", hostValid, 0);

        // Fill, overflow, drain in order
        sendWord(8'h11, 1'b0);
        sendWord(8'h22, 1'b0);
        sendWord(8'h33, 1'b0);
        sendWord(8'h44, 1'b0);
        checkVal("full_count", fifoCount, 4);
        checkVal("full_notready", notReady, 1);
        checkVal("full_no_overrun", overrun, 0);
        sendWord(8'h55, 1'b0);
        checkVal("ovf_overrun", overrun, 1);
        checkVal("ovf_count", fifoCount, 4);
        popWord(8'h11, "drain_0");
        checkVal("drain_notready", notReady, 0);
        popWord(8'h22, "drain_1");
        popWord(8'h33, "drain_2");
        popWord(8'h44, "drain_3");
        checkVal("drain_empty", hostValid, 0);
        checkVal("drain_data_zero", hostData, 0);
        clearFlags();
        checkVal("ovf_clr", overrun, 0);

        // halt with room sets overrun; set beats clear in the same cycle
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checkVal("halt_set", overrun, 1);
        halt = 1'b1; errClr = 1'b1;
        tick();
        halt = 1'b0; errClr = 1'b0;
        checkVal("halt_clr_prio", overrun, 1);
        clearFlags();
        checkVal("halt_clr", overrun, 0);

        // Full FIFO: halt ignored; fifth word with simultaneous pop is stored
        sendWord(8'h61, 1'b0);
        sendWord(8'h62, 1'b0);
        sendWord(8'h63, 1'b0);
        sendWord(8'h64, 1'b0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checkVal("halt_full", overrun, 0);
        rxDatareg = 8'h55;
        received  = 1'b1;
        tick();
        hostReady = 1'b1;
        tick();
        hostReady = 1'b0;
        checkVal("pp_count", fifoCount, 4);
        checkVal("pp_overrun", overrun, 0);
        received = 1'b0;
        tick();
        popWord(8'h62, "pp_0");
        popWord(8'h63, "pp_1");
        popWord(8'h64, "pp_2");
        popWord(8'h55, "pp_3");
        checkVal("pp_empty", fifoCount, 0);

        // Framing error
        sendWord(8'h7E, 1'b1);
        checkVal("ferr_set", frameErr, 1);
`ifdef RX_HOST_ERR_DROP_EN
        checkVal("ferr_count", fifoCount, 0);
        checkVal("ferr_overrun", overrun, 0);
`else
        checkVal("ferr_count", fifoCount, 1);
        checkVal("ferr_data", hostData, 8'h7E);
`endif
        clearFlags();
        checkVal("ferr_clr", frameErr, 0);
`ifndef RX_HOST_ERR_DROP_EN
        popWord(8'h7E, "ferr_pop");
`endif

        // received held high for 20 cycles: one push only
        rxDatareg = 8'h99;
        received  = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        received = 1'b0;
        tick();
        checkVal("hold_count", fifoCount, 1);
        sendWord(8'h9A, 1'b0);
        sendWord(8'h9B, 1'b1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checkVal("prerst_count", fifoCount, 3);
        checkVal("prerst_flags", {overrun, frameErr}, 2'b11);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        checkVal("mrst_count", fifoCount, 0);
        checkVal("mrst_valid", hostValid, 0);
        checkVal("mrst_data", hostData, 0);
        checkVal("mrst_flags", {notReady, overrun, frameErr}, 0);

        // received high across reset is not a new word until seen low
        received = 1'b1;
        rst_b    = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        tick();
        tick();
        checkVal("rst_high_nopush", fifoCount, 0);
        received = 1'b0;
        tick();
        sendWord(8'hC3, 1'b0);
        checkVal("rst_rearm", hostData, 8'hC3);
        popWord(8'hC3, "rst_rearm_pop");

        // Pointer wrap over 10 push/pop pairs
        for (int i = 1; i <= 10; i++) begin
            sendWord(8'(i), 1'b0);
            if (int'(fifoCount) > maxCount) maxCount = int'(fifoCount);
            popWord(8'(i), "wrap_data");
            checkVal("wrap_empty", fifoCount, 0);
        end
        checkVal("wrap_max", maxCount, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/rx_host_ctrl.md
RX_HOST_CTRL -- requirements
Module: rx_host_ctrl

Interface
REQ-001 Parameter wordSize, 8, width of received word and host data.
REQ-002 Parameter fifoDepth, 4, receive FIFO entries; power of two, 2..16.
REQ-003 sampleClk  input  1  single clock for all state; all logic on rising edge.
REQ-004 rst_b  input  1  reset, synchronous, active-low.
REQ-005 rxDatareg  input  wordSize  received word from UART receiver.
REQ-006 received  input  1  receiver word-complete flag, level; a new word is signalled by its 0->1 transition.
REQ-007 error  input  1  receiver framing error, valid while received is high.
REQ-008 halt  input  1  receiver halted, waiting on host.
REQ-009 notReady  output  1  back-pressure to receiver; high when FIFO full.
REQ-010 hostData  output  wordSize  FIFO head word, show-ahead.
REQ-011 hostValid  output  1  FIFO non-empty.
REQ-012 hostReady  input  1  host accepts head word when hostValid is high.
REQ-013 fifoCount  output  log2(fifoDepth)+1  current occupancy.
REQ-014 overrun  output  1  sticky: word lost because FIFO full.
REQ-015 frameErr  output  1  sticky: word captured with error high.
REQ-016 errClr  input  1  clears overrun and frameErr.

Function
REQ-017 Capture FSM states: IDLE, STORE, HOLD; all transitions on sampleClk.
REQ-018 IDLE -> STORE when received is high; rxDatareg and error are registered on that edge.
REQ-019 STORE: push registered word if push is permitted; go to HOLD next cycle unconditionally.
REQ-020 HOLD -> IDLE when received is low; stays in HOLD otherwise, so one received pulse yields exactly one push.
REQ-021 Push permitted when fifoCount < fifoDepth, or when a pop occurs in the same cycle.
REQ-022 Pop occurs when hostValid and hostReady are both high; head advances next edge.
REQ-023 Simultaneous push and pop: fifoCount unchanged; empty-with-push yields no pop.
REQ-024 Pointers wrap modulo fifoDepth; fifoCount ranges 0..fifoDepth and never wraps.
REQ-025 hostValid = (fifoCount != 0); a word pushed at edge N is visible on hostData after edge N, so latency from received rise to hostValid is 2 cycles.
REQ-026 notReady = (fifoCount == fifoDepth), registered from occupancy, no combinational path from inputs.
REQ-027 STORE with push not permitted: word dropped, overrun set next edge.
REQ-028 halt high while notReady high for any cycle: no action; halt with notReady low sets overrun.
REQ-029 Registered error high in STORE with push permitted: frameErr set; word stored.
REQ-030 errClr clears both sticky flags; a set event in the same cycle takes priority.
REQ-031 hostData is 0 when FIFO is empty.

Reset
REQ-032 rst_b low at an edge: FSM IDLE, pointers 0, fifoCount 0, hostValid 0, hostData 0, notReady 0, overrun 0, frameErr 0.
REQ-033 Reset mid-operation discards all FIFO contents and any word in STORE; after release, a received already high is treated as a new word only after it has been seen low.

Configuration
REQ-034 Macro RX_HOST_ERR_DROP_EN defined: a word with registered error high is not pushed; frameErr is still set; overrun is unaffected.
REQ-035 Macro RX_HOST_ERR_DROP_EN undefined: errored words are pushed as per REQ-029.

Verification
REQ-036 Reset; received pulses with rxDatareg=0xA5, hostReady=0 -> hostValid=1 and hostData=0xA5 2 cycles after rise; fifoCount=1.
REQ-037 Four words 0x11,0x22,0x33,0x44, hostReady=0 -> fifoCount=4, notReady=1; fifth word 0x55 -> overrun=1, then pops return 0x11..0x44 in order.
REQ-038 FIFO full, fifth word arrives with hostReady=1 in STORE cycle -> 0x55 stored, fifoCount stays 4, overrun=0.
REQ-039 Word 0x7E with error=1 -> frameErr=1; stored without the macro, absent from FIFO with RX_HOST_ERR_DROP_EN; errClr=1 -> frameErr=0 next cycle.
REQ-040 received held high 20 cycles -> exactly one push; rst_b low for 1 cycle with 3 words queued -> fifoCount=0, hostValid=0, all flags 0.
REQ-041 Pointer wrap: 10 push/pop pairs with values 0x01..0x0A -> data returned in order, fifoCount never exceeds 1.
